spi_shift_engine: RTL and testbench
===================================

Name: spi_shift_engine

Overview:
- SPI master bit engine directly downstream of the cyclic tick generator. It consumes that generator's one-cycle Tick strobe as its half-bit-period timebase.
- Serialises a DATA_W-bit word on Mosi and deserialises Miso into Rx_data.
- Generates Sclk (CPOL/CPHA modes 0-3) and Cs_n.
- Presents a Start/Busy/Done handshake to the register interface above it.

Parameters:
- DATA_W, 8, word length in bits (legal range 2..32).
- CNT_W, $clog2(2*DATA_W)+1, edge-counter width (derived, not overridden).

Ports:
- Clk  input  1  system clock, all logic on posedge.
- Rst  input  1  asynchronous, active-high reset.
- Tick  input  1  half-SCLK-period strobe from the tick generator. Held constantly high is legal.
- Start  input  1  one-cycle transfer request. Sampled only in IDLE.
- Tx_data  input  DATA_W  word to transmit. Latched on accepted Start.
- Cpol  input  1  SCLK idle level. Latched on accepted Start.
- Cpha  input  1  0: sample on leading edge; 1: sample on trailing edge. Latched on accepted Start.
- Miso  input  1  serial data in, synchronous to Clk.
- Busy  output  1  high from the cycle after Start acceptance until Done.
- Done  output  1  one-cycle pulse at transfer end.
- Rx_data  output  DATA_W  received word. Updated together with Done; holds its value otherwise.
- Sclk  output  1  SPI clock, registered.
- Mosi  output  1  serial data out, registered.
- Cs_n  output  1  active-low chip select, registered.

Behaviour:
- Reset (async, Rst=1): state IDLE; Busy=0, Done=0, Rx_data=0, Sclk=0, Mosi=0, Cs_n=1; shift registers and edge counter cleared.
- Reset mid-transfer aborts immediately: no Done pulse, Rx_data cleared.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
- IDLE:
  - Sclk tracks the Cpol input every Clk.
  - On Start=1 (Tick ignored): latch Tx_data, Cpol and Cpha; Cs_n<=0; Busy<=1; go to SETUP.
  - If CPHA=0, Mosi<=Tx_data MSB in the same cycle.
- SETUP: on the next Tick, go to SHIFT with edge counter=0. No Sclk edge occurs.
- SHIFT:
  - Each Tick toggles Sclk and increments the edge counter.
  - Even counts are leading edges; odd counts are trailing edges.
  - CPHA=0: leading edge samples Miso into the rx shifter; trailing edge drives the next tx bit, except after the final edge.
  - CPHA=1: leading edge drives the next tx bit, starting with the MSB; trailing edge samples Miso.
  - After edge 2*DATA_W-1, Sclk is back at Cpol and the FSM goes to HOLD.
- HOLD:
  - On the next Tick: Cs_n<=1, Busy<=0, Done<=1 for exactly one Clk, Rx_data<=rx shifter, Mosi<=0; go to IDLE.
- Latency: Start to Done = 2*DATA_W+2 Ticks after acceptance.
- Tick constantly high (Ticks=0 upstream): the engine advances on every Clk.
- Start while Busy=1 is ignored; it is neither queued nor an error.
- Start coinciding with Done is ignored. A new Start is accepted no earlier than the cycle after Done.
- Tick arriving in the same cycle as an accepted Start has no effect. SETUP always waits for a later Tick.
- Cpol, Cpha and Tx_data changes during Busy have no effect on the transfer in progress.
- Edge counter never wraps: it is cleared on entry to SHIFT and is only compared against 2*DATA_W-1.

Optional Feature:
- Macro: SPI_LSB_FIRST_EN.
- Defined: adds input port Lsb_first (1 bit), latched on accepted Start. When 1, Tx_data[0] is shifted first and received bits are assembled so that the first received bit lands in Rx_data[0].
- Undefined: no Lsb_first port; MSB-first only, with the first received bit landing in Rx_data[DATA_W-1].

Decomposition:
- Shared package spi_pkg: state encoding typedef (IDLE, SETUP, SHIFT, HOLD) and SPI mode constants (MODE0..MODE3 as {Cpol,Cpha}).
- The rx shifter stays inline.
- One natural sub-module, spi_sclk_gen: Sclk toggle, edge counter, and leading/trailing edge strobes driven from Tick.

Test Plan:
- Mode 0, DATA_W=8, Tick every 3 Clk, Tx_data=0xA5, Miso looped back from Mosi -> Mosi bit sequence 1,0,1,0,0,1,0,1; 8 rising Sclk edges; Done after 18 Ticks; Rx_data=0xA5.
- Mode 3, Tx_data=0x3C, Miso driven from a slave model returning 0xC3 -> Sclk idles high; Rx_data=0xC3; Cs_n low for exactly 18 Ticks worth of cycles.
- Tick tied high, Mode 1, Tx_data=0xFF, Miso=0 -> Done on Clk 19 after Start; Rx_data=0x00; Busy high for 18 cycles.
- Start pulsed again mid-transfer and in the Done cycle -> both ignored; exactly one Done; Busy stays continuous.
- Assert Rst at edge 5 of a Mode 2 transfer -> immediately Cs_n=1, Busy=0, Sclk=0, Rx_data=0, no Done; a subsequent transfer of 0x5A completes correctly.
- With SPI_LSB_FIRST_EN defined, Lsb_first=1, Tx_data=0x01, loopback -> first Mosi bit is 1; Rx_data=0x01.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the SPI shift engine: FSM state encoding and {Cpol,Cpha} mode constants.
package spi_pkg;

    typedef logic [1:0] spi_state_t;

    localparam spi_state_t ST_IDLE  = 2'd0;
    localparam spi_state_t ST_SETUP = 2'd1;
    localparam spi_state_t ST_SHIFT = 2'd2;
    localparam spi_state_t ST_HOLD  = 2'd3;

    typedef logic [1:0] spi_mode_t;

    localparam spi_mode_t MODE0 = 2'b00;
    localparam spi_mode_t MODE1 = 2'b01;
    localparam spi_mode_t MODE2 = 2'b10;
    localparam spi_mode_t MODE3 = 2'b11;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: tracks Cpol while idle, toggles on each Tick while shifting, and
// flags leading/trailing edges from the parity of the edge counter.
module spi_sclk_gen #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = $clog2(2*DATA_W)+1
) (
    input  logic Clk,
    input  logic Rst,
    input  logic tick,
    input  logic idle,
    input  logic cpol,
    input  logic clear,
    input  logic shift_en,
    output logic sclk,
    output logic lead_stb,
    output logic trail_stb,
    output logic last_edge
);

    localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2*DATA_W-1);

    logic [CNT_W-1:0] edge_cnt;

    always_comb begin
        lead_stb  = shift_en & tick & ~edge_cnt[0];
        trail_stb = shift_en & tick &  edge_cnt[0];
        last_edge = trail_stb && (edge_cnt == LAST_EDGE);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sclk     <= 1'b0;
            edge_cnt <= '0;
        end else begin
            if (idle) begin
                sclk <= cpol;
            end else if (shift_en && tick) begin
                sclk <= ~sclk;
            end

            if (clear) begin
                edge_cnt <= '0;
            end else if (shift_en && tick) begin
                edge_cnt <= edge_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master bit engine clocked by the half-period Tick strobe (modes 0-3).
// Optional SPI_LSB_FIRST_EN adds a Lsb_first port selecting LSB-first shifting.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = $clog2(2*DATA_W)+1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Tick,
    input  logic              Start,
    input  logic [DATA_W-1:0] Tx_data,
    input  logic              Cpol,
    input  logic              Cpha,
    input  logic              Miso,
`ifdef SPI_LSB_FIRST_EN
    input  logic              Lsb_first,
`endif
    output logic              Busy,
    output logic              Done,
    output logic [DATA_W-1:0] Rx_data,
    output logic              Sclk,
    output logic              Mosi,
    output logic              Cs_n
);

    spi_state_t        state;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] tx_next;
    logic [DATA_W-1:0] ld_next;
    logic [DATA_W-1:0] rx_in;
    logic              tx_head;
    logic              ld_head;
    logic              cpha_q;
    logic              lsb_in;
    logic              lsb_q;
    logic              accept;
    logic              lead_stb;
    logic              trail_stb;
    logic              last_edge;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_in = Lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    // Done is high in the first IDLE cycle; a Start there must not be taken.
    assign accept = (state == ST_IDLE) && Start && !Done;

    always_comb begin
        tx_head = lsb_q  ? tx_shift[0] : tx_shift[DATA_W-1];
        tx_next = lsb_q  ? (tx_shift >> 1) : (tx_shift << 1);
        ld_head = lsb_in ? Tx_data[0] : Tx_data[DATA_W-1];
        ld_next = lsb_in ? (Tx_data >> 1) : (Tx_data << 1);
        rx_in   = lsb_q  ? {Miso, rx_shift[DATA_W-1:1]} : {rx_shift[DATA_W-2:0], Miso};
    end

    // Cpol is captured by Sclk itself: it follows Cpol in IDLE up to the accepting edge.
    spi_sclk_gen #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_sclk_gen (
        .Clk       (Clk),
        .Rst       (Rst),
        .tick      (Tick),
        .idle      (state == ST_IDLE),
        .cpol      (Cpol),
        .clear     ((state == ST_SETUP) && Tick),
        .shift_en  (state == ST_SHIFT),
        .sclk      (Sclk),
        .lead_stb  (lead_stb),
        .trail_stb (trail_stb),
        .last_edge (last_edge)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state    <= ST_IDLE;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Rx_data  <= '0;
            Mosi     <= 1'b0;
            Cs_n     <= 1'b1;
            tx_shift <= '0;
            rx_shift <= '0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cpha_q   <= Cpha;
                        lsb_q    <= lsb_in;
                        rx_shift <= '0;
                        Cs_n     <= 1'b0;
                        Busy     <= 1'b1;
                        state    <= ST_SETUP;
                        if (!Cpha) begin
                            Mosi     <= ld_head;
                            tx_shift <= ld_next;
                        end else begin
                            tx_shift <= Tx_data;
                        end
                    end
                end
                ST_SETUP: begin
                    if (Tick) begin
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (lead_stb) begin
                        if (!cpha_q) begin
                            rx_shift <= rx_in;
                        end else begin
                            Mosi     <= tx_head;
                            tx_shift <= tx_next;
                        end
                    end
                    if (trail_stb) begin
                        if (cpha_q) begin
                            rx_shift <= rx_in;
                        end else if (!last_edge) begin
                            Mosi     <= tx_head;
                            tx_shift <= tx_next;
                        end
                    end
                    if (last_edge) begin
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (Tick) begin
                        Cs_n    <= 1'b1;
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                        Rx_data <= rx_shift;
                        Mosi    <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed self-checking bench for spi_shift_engine (DATA_W=8); LSB-first case only
// when SPI_LSB_FIRST_EN is defined.
module tb_spi_shift_engine;
    import spi_pkg::*;

    logic       Clk;
    logic       Rst;
    logic       Tick;
    logic       Start;
    logic [7:0] Tx_data;
    logic       Cpol;
    logic       Cpha;
    logic       Miso;
`ifdef SPI_LSB_FIRST_EN
    logic       Lsb_first;
`endif
    logic       Busy;
    logic       Done;
    logic [7:0] Rx_data;
    logic       Sclk;
    logic       Mosi;
    logic       Cs_n;

    int n_checks = 0;
    int n_err    = 0;

    logic       tick_all;
    int         tick_cnt = 0;
    int         miso_sel;
    logic       miso_const;
    logic       slave_bit;
    logic [7:0] slave_word;
    int         slave_idx;
    bit         slave_en;
    bit         log_en;
    logic [7:0] mosi_log;
    int         rises;
    int         done_total = 0;
    logic       first_mosi;
    int         n_cyc, n_tick, n_busy, n_csl;
    int         d0, busy_hi;

    spi_shift_engine #(
        .DATA_W (8)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Tick      (Tick),
        .Start     (Start),
        .Tx_data   (Tx_data),
        .Cpol      (Cpol),
        .Cpha      (Cpha),
        .Miso      (Miso),
`ifdef SPI_LSB_FIRST_EN
        .Lsb_first (Lsb_first),
`endif
        .Busy      (Busy),
        .Done      (Done),
        .Rx_data   (Rx_data),
        .Sclk      (Sclk),
        .Mosi      (Mosi),
        .Cs_n      (Cs_n)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Tick generator: every third Clk, or constantly high.
    always @(posedge Clk) tick_cnt <= (tick_cnt == 2) ? 0 : tick_cnt + 1;
    assign Tick = tick_all | (tick_cnt == 0);

    assign Miso = (miso_sel == 1) ? Mosi : (miso_sel == 2) ? slave_bit : miso_const;

    // Mode-3 slave: presents the next bit on each falling (leading) Sclk edge.
    always @(negedge Sclk) begin
        if (slave_en && slave_idx >= 0) begin
            slave_bit = slave_word[slave_idx];
            slave_idx = slave_idx - 1;
        end
    end

    always @(posedge Sclk) begin
        if (log_en) begin
            mosi_log = {mosi_log[6:0], Mosi};
            rises    = rises + 1;
        end
    end

    always @(posedge Done) done_total = done_total + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_xfer(input logic [7:0] tx, input bit align, input int mid_evt);
        int guard;
        bit got;
        Tx_data = tx;
        guard = 0;
        if (align) begin
            while (!Tick && guard < 10) begin
                @(negedge Clk);
                guard++;
            end
        end
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        first_mosi = Mosi;
        n_cyc = 0; n_tick = 0; n_busy = 0; n_csl = 0;
        got = 1'b0;
        while (!got && n_cyc < 300) begin
            n_busy += int'(Busy);
            n_csl  += int'(!Cs_n);
            if (Tick) n_tick++;
            Start = (n_cyc == mid_evt);
            if (n_cyc == mid_evt) begin
                Tx_data = ~tx;
                Cpha    = ~Cpha;
            end
            @(negedge Clk);
            n_cyc++;
            got = Done;
        end
        Start = 1'b0;
        check("done_seen", 32'(got), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b1; Start = 1'b0; Tx_data = '0; Cpol = 1'b0; Cpha = 1'b0;
        tick_all = 1'b0; miso_sel = 0; miso_const = 1'b0; slave_bit = 1'b0;
        slave_word = '0; slave_idx = -1; slave_en = 1'b0; log_en = 1'b0;
        mosi_log = '0; rises = 0;
`ifdef SPI_LSB_FIRST_EN
        Lsb_first = 1'b0;
`endif
        repeat (3) @(negedge Clk);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_rx",   32'(Rx_data), 32'h00);
        check("rst_sclk", 32'(Sclk), 32'd0);
        check("rst_mosi", 32'(Mosi), 32'd0);
        check("rst_csn",  32'(Cs_n), 32'd1);
        Rst = 1'b0;
        repeat (2) @(negedge Clk);

        // Mode 0, Tick every 3 Clk, loopback, start aligned with a Tick
        miso_sel = 1; {Cpol, Cpha} = MODE0; mosi_log = '0; rises = 0; log_en = 1'b1;
        run_xfer(8'hA5, 1'b1, -1);
        log_en = 1'b0;
        check("m0_mosi_seq", 32'(mosi_log), 32'hA5);
        check("m0_rises",    32'(rises), 32'd8);
        check("m0_ticks",    32'(n_tick), 32'd18);
        check("m0_cycles",   32'(n_cyc), 32'd54);
        check("m0_busy",     32'(n_busy), 32'd54);
        check("m0_rx",       32'(Rx_data), 32'hA5);
        @(negedge Clk);
        check("m0_done_width", 32'(Done), 32'd0);

        // Mode 1, Tick held high, Miso=0
        tick_all = 1'b1; miso_sel = 0; miso_const = 1'b0; {Cpol, Cpha} = MODE1;
        repeat (2) @(negedge Clk);
        run_xfer(8'hFF, 1'b0, -1);
        check("m1_cycles", 32'(n_cyc), 32'd18);
        check("m1_busy",   32'(n_busy), 32'd18);
        check("m1_ticks",  32'(n_tick), 32'd18);
        check("m1_rx",     32'(Rx_data), 32'h00);

        // Mode 3 against a slave returning 0xC3, Tick every 3 Clk
        tick_all = 1'b0; {Cpol, Cpha} = MODE3;
        repeat (2) @(negedge Clk);
        check("m3_sclk_idle", 32'(Sclk), 32'd1);
        slave_word = 8'hC3; slave_idx = 7; slave_en = 1'b1; miso_sel = 2;
        run_xfer(8'h3C, 1'b1, -1);
        slave_en = 1'b0;
        check("m3_rx",        32'(Rx_data), 32'hC3);
        check("m3_csn_low",   32'(n_csl), 32'd54);
        check("m3_ticks",     32'(n_tick), 32'd18);
        check("m3_sclk_end",  32'(Sclk), 32'd1);

        // Start mid-transfer (with Tx_data/Cpha disturbed) and in the Done cycle
        tick_all = 1'b1; miso_sel = 1; {Cpol, Cpha} = MODE0;
        repeat (2) @(negedge Clk);
        d0 = done_total;
        run_xfer(8'h96, 1'b0, 8);
        check("ign_rx",     32'(Rx_data), 32'h96);
        check("ign_cycles", 32'(n_cyc), 32'd18);
        check("ign_busy",   32'(n_busy), 32'd18);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        check("ign_done_start_busy", 32'(Busy), 32'd0);
        check("ign_done_start_csn",  32'(Cs_n), 32'd1);
        busy_hi = 0;
        repeat (20) begin
            @(negedge Clk);
            busy_hi += int'(Busy);
        end
        check("ign_no_restart", 32'(busy_hi), 32'd0);
        check("ign_one_done",   32'(done_total - d0), 32'd1);

        // Mode 2, reset asserted just before Sclk edge 5
        {Cpol, Cpha} = MODE2; Tx_data = 8'h5A;
        repeat (2) @(negedge Clk);
        d0 = done_total;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (6) @(negedge Clk);
        check("rst_mid_busy_before", 32'(Busy), 32'd1);
        Rst = 1'b1;
        #1;
        check("rst_mid_csn",  32'(Cs_n), 32'd1);
        check("rst_mid_busy", 32'(Busy), 32'd0);
        check("rst_mid_sclk", 32'(Sclk), 32'd0);
        check("rst_mid_rx",   32'(Rx_data), 32'h00);
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_mid_no_done", 32'(done_total - d0), 32'd0);
        check("rst_mid_sclk_idle", 32'(Sclk), 32'd1);

        run_xfer(8'h5A, 1'b0, -1);
        check("m2_rx",     32'(Rx_data), 32'h5A);
        check("m2_cycles", 32'(n_cyc), 32'd18);

`ifdef SPI_LSB_FIRST_EN
        // LSB-first loopback of 0x01
        Lsb_first = 1'b1; {Cpol, Cpha} = MODE0; mosi_log = '0; rises = 0;
        repeat (2) @(negedge Clk);
        log_en = 1'b1;
        run_xfer(8'h01, 1'b0, -1);
        log_en = 1'b0;
        Lsb_first = 1'b0;
        check("lsb_first_mosi", 32'(first_mosi), 32'd1);
        check("lsb_mosi_seq",   32'(mosi_log), 32'h80);
        check("lsb_rx",         32'(Rx_data), 32'h01);
`endif

        repeat (2) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
